// File: rtl/dual_ad7528_pkg.sv
// Shared types and helpers for the dual AD7528 serial writer.
package dual_ad7528_pkg;

  typedef enum logic [1:0] {
    LEFT_A  = 2'd0,
    LEFT_B  = 2'd1,
    RIGHT_A = 2'd2,
    RIGHT_B = 2'd3
  } dac_target_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_SEL,
    ST_STROBE,
    ST_RECOVER
  } writer_state_t;

  localparam logic [2:0] MSB_IDX = 3'd7;

  function automatic logic is_a_side(input dac_target_t t);
    return (t == LEFT_A) || (t == RIGHT_A);
  endfunction

  function automatic logic is_right(input dac_target_t t);
    return (t == RIGHT_A) || (t == RIGHT_B);
  endfunction

endpackage

// File: rtl/dual_ad7528_phase_timer.sv
// Protocol phase timer: restart loads HALF_PERIOD-1, phase_end_o flags the last cycle of a phase.
module dual_ad7528_phase_timer #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/dual_ad7528_serial_writer.sv
// Serial writer for two AD7528 DACs behind a 74HC164: shifts the word, selects A/B, strobes CS.
// Optional shadow registers enabled by `define DUAL_AD7528_SHADOW_EN.
module dual_ad7528_serial_writer
  import dual_ad7528_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_target,
  input  logic [7:0] wr_value,
  output logic       wr_done,
  output logic       datadac,
  output logic       clkdac,
  output logic       csdac1n,
  output logic       csdac2n,
  output logic [7:0] shadow_left_a,
  output logic [7:0] shadow_left_b,
  output logic [7:0] shadow_right_a,
  output logic [7:0] shadow_right_b
);

  writer_state_t state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    val_q, val_d;
  dac_target_t   tgt_q, tgt_d;
  logic          phase_end, restart;

  logic wr_ready_q, wr_ready_d;
  logic wr_done_q, wr_done_d;
  logic datadac_q, datadac_d;
  logic clkdac_q, clkdac_d;
  logic cs1n_q, cs1n_d;
  logic cs2n_q, cs2n_d;

  dual_ad7528_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .restart_i  (restart),
    .phase_end_o(phase_end)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    tgt_d   = tgt_q;
    restart = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_valid && wr_ready_q) begin
          val_d   = wr_value;
          tgt_d   = dac_target_t'(wr_target);
          idx_d   = MSB_IDX;
          state_d = ST_BIT_LO;
          restart = 1'b1;
        end
      end
      ST_BIT_LO:  if (phase_end) state_d = ST_BIT_HI;
      ST_BIT_HI: begin
        if (phase_end) begin
          if (idx_q == 3'd0) begin
            state_d = ST_SEL;
          end else begin
            idx_d   = idx_q - 3'd1;
            state_d = ST_BIT_LO;
          end
        end
      end
      ST_SEL:     if (phase_end) state_d = ST_STROBE;
      ST_STROBE:  if (phase_end) state_d = ST_RECOVER;
      ST_RECOVER: if (phase_end) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && phase_end) begin
      restart = 1'b1;
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    wr_ready_d = (state_d == ST_IDLE);
    wr_done_d  = (state_q == ST_RECOVER) && (state_d == ST_IDLE);
    clkdac_d   = (state_d == ST_BIT_HI);
    cs1n_d     = !((state_d == ST_STROBE) && !is_right(tgt_d));
    cs2n_d     = !((state_d == ST_STROBE) && is_right(tgt_d));
    datadac_d  = datadac_q;
    case (state_d)
      ST_IDLE:   datadac_d = 1'b0;
      ST_BIT_LO: datadac_d = val_d[idx_d];
      ST_SEL:    datadac_d = is_a_side(tgt_d);
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      val_q      <= '0;
      tgt_q      <= LEFT_A;
      wr_ready_q <= 1'b1;
      wr_done_q  <= 1'b0;
      datadac_q  <= 1'b0;
      clkdac_q   <= 1'b0;
      cs1n_q     <= 1'b1;
      cs2n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      tgt_q      <= tgt_d;
      wr_ready_q <= wr_ready_d;
      wr_done_q  <= wr_done_d;
      datadac_q  <= datadac_d;
      clkdac_q   <= clkdac_d;
      cs1n_q     <= cs1n_d;
      cs2n_q     <= cs2n_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign wr_done  = wr_done_q;
  assign datadac  = datadac_q;
  assign clkdac   = clkdac_q;
  assign csdac1n  = cs1n_q;
  assign csdac2n  = cs2n_q;

`ifdef DUAL_AD7528_SHADOW_EN
  logic [7:0] sh_la_q, sh_lb_q, sh_ra_q, sh_rb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_la_q <= '0;
      sh_lb_q <= '0;
      sh_ra_q <= '0;
      sh_rb_q <= '0;
    end else if (state_q == ST_STROBE && phase_end) begin
      case (tgt_q)
        LEFT_A:  sh_la_q <= val_q;
        LEFT_B:  sh_lb_q <= val_q;
        RIGHT_A: sh_ra_q <= val_q;
        RIGHT_B: sh_rb_q <= val_q;
        default: ;
      endcase
    end
  end

  assign shadow_left_a  = sh_la_q;
  assign shadow_left_b  = sh_lb_q;
  assign shadow_right_a = sh_ra_q;
  assign shadow_right_b = sh_rb_q;
`else
  assign shadow_left_a  = '0;
  assign shadow_left_b  = '0;
  assign shadow_right_a = '0;
  assign shadow_right_b = '0;
`endif

endmodule

// File: tb/tb_dual_ad7528_serial_writer.sv
// Directed self-checking bench for dual_ad7528_serial_writer with a behavioural AD7528 receiver.
module tb_dual_ad7528_serial_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_target = 2'd0;
  logic [7:0] wr_value = 8'd0;
  logic       wr_ready, wr_done, datadac, clkdac, csdac1n, csdac2n;
  logic [7:0] shadow_left_a, shadow_left_b, shadow_right_a, shadow_right_b;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_sh [4];

  dual_ad7528_serial_writer #(
    .HALF_PERIOD(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_target     (wr_target),
    .wr_value      (wr_value),
    .wr_done       (wr_done),
    .datadac       (datadac),
    .clkdac        (clkdac),
    .csdac1n       (csdac1n),
    .csdac2n       (csdac2n),
    .shadow_left_a (shadow_left_a),
    .shadow_left_b (shadow_left_b),
    .shadow_right_a(shadow_right_a),
    .shadow_right_b(shadow_right_b)
  );

  always #5 clk = ~clk;

  // Receiver: 74HC164 shifting on clkdac rise, AD7528 latching on CS rise with datadac as A/B select.
  logic [7:0] rx_sr = '0;
  logic [7:0] rx_la = '0, rx_lb = '0, rx_ra = '0, rx_rb = '0;
  logic rx_arm1 = 1'b0, rx_arm2 = 1'b0;
  int rx_str1 = 0, rx_str2 = 0;

  always @(posedge clkdac) rx_sr = {rx_sr[6:0], datadac};

  always @(csdac1n) begin
    if (csdac1n === 1'b0) begin
      rx_arm1 = 1'b1;
      rx_str1++;
    end else if (rx_arm1) begin
      if (datadac) rx_la = rx_sr; else rx_lb = rx_sr;
      rx_arm1 = 1'b0;
    end
  end

  always @(csdac2n) begin
    if (csdac2n === 1'b0) begin
      rx_arm2 = 1'b1;
      rx_str2++;
    end else if (rx_arm2) begin
      if (datadac) rx_ra = rx_sr; else rx_rb = rx_sr;
      rx_arm2 = 1'b0;
    end
  end

  function automatic logic [31:0] shadows();
    return {shadow_left_a, shadow_left_b, shadow_right_a, shadow_right_b};
  endfunction

  function automatic logic [31:0] exp_shadows();
    return {exp_sh[0], exp_sh[1], exp_sh[2], exp_sh[3]};
  endfunction

  function automatic logic [7:0] rx_reg(input logic [1:0] t);
    case (t)
      2'd0: return rx_la;
      2'd1: return rx_lb;
      2'd2: return rx_ra;
      default: return rx_rb;
    endcase
  endfunction

  function automatic logic [5:0] pins();
    return {wr_ready, wr_done, datadac, clkdac, csdac1n, csdac2n};
  endfunction

  // One complete write; returns observations, leaves the bench on the wr_done cycle.
  task automatic run_xfer(input logic [1:0] tgt, input logic [7:0] val,
                          output logic [7:0] bits, output int cs1_low, output int cs2_low,
                          output int cs_data_bad, output int done_cyc, output int viol,
                          output logic [31:0] sh_strobe, output logic [31:0] sh_rise);
    int w;
    logic prev_clk, prev_data, prev_cs;
    bits = '0; cs1_low = 0; cs2_low = 0; cs_data_bad = 0; done_cyc = -1; viol = 0;
    sh_strobe = '0; sh_rise = '0;
    @(negedge clk);
    wr_valid = 1'b1; wr_target = tgt; wr_value = val;
    w = 0;
    while (wr_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      wr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0; wr_target = ~tgt; wr_value = ~val;
    prev_clk = 1'b0; prev_data = 1'b0; prev_cs = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (clkdac && !prev_clk) bits = {bits[6:0], datadac};
      if (!csdac1n) begin
        cs1_low++;
        if (datadac !== !tgt[0]) cs_data_bad++;
      end
      if (!csdac2n) begin
        cs2_low++;
        if (datadac !== !tgt[0]) cs_data_bad++;
      end
      if (!csdac1n && !csdac2n) viol++;
      if (clkdac && (!csdac1n || !csdac2n)) viol++;
      if (datadac !== prev_data && (clkdac || !csdac1n || !csdac2n)) viol++;
      if (!(csdac1n && csdac2n)) sh_strobe = shadows();
      if (!prev_cs && csdac1n && csdac2n) sh_rise = shadows();
      prev_clk = clkdac; prev_data = datadac; prev_cs = csdac1n && csdac2n;
      if (wr_done) begin
        done_cyc = n;
        break;
      end
    end
`ifdef DUAL_AD7528_SHADOW_EN
    if (done_cyc > 0) exp_sh[tgt] = val;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_sh[i] = '0;
    total++;
    if (pins() !== 6'b100011) begin
      bad++;
      $display("FAIL reset_pins: got %b want %b", pins(), 6'b100011);
    end
    total++;
    if (shadows() !== 32'h0) begin
      bad++;
      $display("FAIL reset_shadows: got %h want 0", shadows());
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_left_a();
    logic [7:0] bits; int c1, c2, cdb, dc, v; logic [31:0] ss, sr;
    run_xfer(2'd0, 8'hA5, bits, c1, c2, cdb, dc, v, ss, sr);
    total++; if (bits !== 8'hA5) begin bad++; $display("FAIL la_bits: got %h want a5", bits); end
    total++; if (c1 !== 2) begin bad++; $display("FAIL la_cs1_len: got %0d want 2", c1); end
    total++; if (c2 !== 0) begin bad++; $display("FAIL la_cs2_len: got %0d want 0", c2); end
    total++; if (cdb !== 0) begin bad++; $display("FAIL la_sel: got %0d bad cycles want 0", cdb); end
    total++; if (dc !== 39) begin bad++; $display("FAIL la_latency: got %0d want 39", dc); end
    total++; if (v !== 0) begin bad++; $display("FAIL la_protocol: got %0d violations want 0", v); end
    total++;
    if ({wr_ready, datadac} !== 2'b10) begin
      bad++; $display("FAIL la_done_cycle: got ready,data=%b want 10", {wr_ready, datadac});
    end
    total++; if (rx_la !== 8'hA5) begin bad++; $display("FAIL la_rx: got %h want a5", rx_la); end
    @(negedge clk);
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL la_done_pulse: got %b want 0", wr_done); end
  endtask

  task automatic test_right_b();
    logic [7:0] bits; int c1, c2, cdb, dc, v; logic [31:0] ss, sr;
    run_xfer(2'd3, 8'h3C, bits, c1, c2, cdb, dc, v, ss, sr);
    total++; if (bits !== 8'h3C) begin bad++; $display("FAIL rb_bits: got %h want 3c", bits); end
    total++; if (c2 !== 2) begin bad++; $display("FAIL rb_cs2_len: got %0d want 2", c2); end
    total++; if (c1 !== 0) begin bad++; $display("FAIL rb_cs1_len: got %0d want 0", c1); end
    total++; if (cdb !== 0) begin bad++; $display("FAIL rb_sel: got %0d bad cycles want 0", cdb); end
    total++; if (v !== 0) begin bad++; $display("FAIL rb_protocol: got %0d violations want 0", v); end
    total++; if (rx_rb !== 8'h3C) begin bad++; $display("FAIL rb_rx: got %h want 3c", rx_rb); end
  endtask

  task automatic test_all_targets();
    logic [7:0] vals [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
    logic [7:0] bits; int c1, c2, cdb, dc, v; logic [31:0] ss, sr;
    for (int vi = 0; vi < 4; vi++) begin
      for (int t = 0; t < 4; t++) begin
        run_xfer(2'(t), vals[vi], bits, c1, c2, cdb, dc, v, ss, sr);
        total++;
        if (rx_reg(2'(t)) !== vals[vi] || dc !== 39 || v !== 0) begin
          bad++;
          $display("FAIL all_tgt t=%0d: got rx=%h lat=%0d viol=%0d want rx=%h lat=39 viol=0",
                   t, rx_reg(2'(t)), dc, v, vals[vi]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    logic [1:0] tgts [3] = '{2'd0, 2'd2, 2'd1};
    int acc [3];
    int k = 0, c = 0, overlap = 0, dnmiss = 0, s1 = rx_str1, s2 = rx_str2;
    logic done_seen = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1; wr_target = tgts[0]; wr_value = vals[0];
    while (k < 3 && c < 400) begin
      if (!csdac1n && !csdac2n) overlap++;
      if (wr_ready) begin
        acc[k] = c;
        if (k > 0 && !wr_done) dnmiss++;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) begin
          wr_target = tgts[k]; wr_value = vals[k];
        end else begin
          wr_valid = 1'b0;
        end
      end
      @(negedge clk);
      c++;
    end
    for (int n = 0; n < 100 && !done_seen; n++) begin
      if (!csdac1n && !csdac2n) overlap++;
      if (wr_done) done_seen = 1'b1; else @(negedge clk);
    end
    total++; if (k !== 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", k); end
    total++;
    if (k == 3 && (acc[1] - acc[0] !== 39 || acc[2] - acc[1] !== 39)) begin
      bad++; $display("FAIL b2b_spacing: got %0d,%0d want 39,39", acc[1] - acc[0], acc[2] - acc[1]);
    end
    total++; if (dnmiss !== 0) begin bad++; $display("FAIL b2b_done_at_accept: got %0d misses want 0", dnmiss); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
    total++; if (!done_seen) begin bad++; $display("FAIL b2b_final_done: got none want pulse"); end
    total++;
    if ({rx_la, rx_ra, rx_lb} !== 24'h112233) begin
      bad++; $display("FAIL b2b_rx: got %h want 112233", {rx_la, rx_ra, rx_lb});
    end
    total++;
    if (rx_str1 - s1 !== 2 || rx_str2 - s2 !== 1) begin
      bad++; $display("FAIL b2b_strobes: got %0d,%0d want 2,1", rx_str1 - s1, rx_str2 - s2);
    end
`ifdef DUAL_AD7528_SHADOW_EN
    exp_sh[0] = 8'h11; exp_sh[2] = 8'h22; exp_sh[1] = 8'h33;
`endif
    total++;
    if (shadows() !== exp_shadows()) begin
      bad++; $display("FAIL b2b_shadows: got %h want %h", shadows(), exp_shadows());
    end
  endtask

  task automatic test_reset_mid();
    int rises = 0, lowcnt = 0, w = 0, s1, s2;
    logic prev = 1'b0;
    logic [7:0] la_before = rx_la;
    logic [7:0] bits; int c1, c2, cdb, dc, v; logic [31:0] ss, sr;
    s1 = rx_str1; s2 = rx_str2;
    @(negedge clk);
    wr_valid = 1'b1; wr_target = 2'd0; wr_value = 8'hFF;
    while (wr_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    for (int n = 0; n < 100 && rises < 5; n++) begin
      @(negedge clk);
      if (clkdac && !prev) rises++;
      prev = clkdac;
    end
    total++; if (rises !== 5 || clkdac !== 1'b1) begin bad++; $display("FAIL rst_mid_reach: got rises=%0d clk=%b want 5,1", rises, clkdac); end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_sh[i] = '0;
    total++; if (pins() !== 6'b100011) begin bad++; $display("FAIL rst_mid_pins: got %b want %b", pins(), 6'b100011); end
    total++; if (shadows() !== 32'h0) begin bad++; $display("FAIL rst_mid_shadows: got %h want 0", shadows()); end
    reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!csdac1n || !csdac2n) lowcnt++;
    end
    total++;
    if (lowcnt !== 0 || rx_str1 !== s1 || rx_str2 !== s2 || rx_la !== la_before) begin
      bad++; $display("FAIL rst_mid_no_strobe: got low=%0d str=%0d,%0d la=%h want 0,%0d,%0d,%h",
                      lowcnt, rx_str1, rx_str2, rx_la, s1, s2, la_before);
    end
    run_xfer(2'd2, 8'h5A, bits, c1, c2, cdb, dc, v, ss, sr);
    total++;
    if (rx_ra !== 8'h5A || dc !== 39 || v !== 0) begin
      bad++; $display("FAIL rst_mid_recover: got rx=%h lat=%0d viol=%0d want 5a,39,0", rx_ra, dc, v);
    end
  endtask

  task automatic test_shadow();
    logic [7:0] bits; int c1, c2, cdb, dc, v; logic [31:0] ss, sr, pre, post;
    pre = exp_shadows();
    run_xfer(2'd1, 8'h42, bits, c1, c2, cdb, dc, v, ss, sr);
    post = exp_shadows();
    total++; if (ss !== pre) begin bad++; $display("FAIL sh_during_strobe: got %h want %h", ss, pre); end
    total++; if (sr !== post) begin bad++; $display("FAIL sh_at_strobe_end: got %h want %h", sr, post); end
    total++; if (shadows() !== post) begin bad++; $display("FAIL sh_final: got %h want %h", shadows(), post); end
    total++; if (rx_lb !== 8'h42) begin bad++; $display("FAIL sh_rx: got %h want 42", rx_lb); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_sh[i] = '0;
    test_reset();
    test_left_a();
    test_right_b();
    test_all_targets();
    test_back_to_back();
    test_reset_mid();
    test_shadow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_ad7528_serial_writer.md
Name: dual_ad7528_serial_writer

Overview:
- Transmit end of the dual AD7528 attenuation DAC serial interface.
- Accepts one 8-bit attenuation word plus a target (LEFT_A, LEFT_B, RIGHT_A or RIGHT_B) through a valid/ready handshake.
- Produces datadac, clkdac, csdac1n and csdac2n:
  - shifts the word MSB first into the external 74HC164;
  - presents the A/B select on datadac;
  - pulses the chip select of the addressed DAC.
- Replaces slave-MCU bit-banging so that core logic can program the audio attenuation directly.

Parameters:
- HALF_PERIOD, 4: clk cycles per protocol phase. Minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  block idle; request accepted when wr_valid && wr_ready
- wr_target  in  2  0=LEFT_A, 1=LEFT_B, 2=RIGHT_A, 3=RIGHT_B
- wr_value  in  8  attenuation factor
- wr_done  out  1  one-cycle pulse when a transfer completes
- datadac  out  1  serial data / A-B select
- clkdac  out  1  shift clock; the receiver shifts on its rising edge
- csdac1n  out  1  left DAC latch strobe, active low
- csdac2n  out  1  right DAC latch strobe, active low
- shadow_left_a, shadow_left_b, shadow_right_a, shadow_right_b  out  8 each  last values written (see Optional Feature)

Behaviour:
- All outputs are registered. Reset values:
  - wr_ready=1, wr_done=0;
  - datadac=0, clkdac=0, csdac1n=1, csdac2n=1;
  - shadows=0.
- Acceptance: on a cycle with wr_valid && wr_ready, wr_value and wr_target are captured and wr_ready drops next cycle. wr_valid with wr_ready=0 is ignored; the requester holds it.
- States: IDLE, BIT_LO, BIT_HI, SEL, STROBE, RECOVER. Every non-IDLE state lasts exactly HALF_PERIOD cycles, timed by a phase counter.
- Bit sequence:
  - IDLE -> BIT_LO with bit index 7.
  - BIT_LO: datadac=value[idx], clkdac=0.
  - BIT_HI: clkdac=1, datadac held.
  - BIT_HI -> BIT_LO with idx-1, or -> SEL after idx 0.
- SEL: clkdac=0; datadac = 1 for an A target, 0 for a B target.
- STROBE: csdac1n=0 for target 0/1, or csdac2n=0 for target 2/3; datadac held.
- RECOVER: both chip selects high; datadac held.
- RECOVER -> IDLE. In the first IDLE cycle wr_done=1 and wr_ready=1; datadac returns to 0.
- Transfer latency: accept cycle + 19*HALF_PERIOD cycles, then the wr_done cycle.
- Back-to-back: a new request may be accepted in the wr_done cycle.
- At most one chip select is low at any time. clkdac and the chip selects are never low-true simultaneously.
- datadac changes only in the cycle that enters BIT_LO, SEL or IDLE, never while clkdac=1 or a chip select is low.
- Reset mid-transfer: all outputs return to reset values on the next edge and no strobe is emitted. The partially shifted receiver register is harmless because only a strobe latches it.
- wr_value and wr_target changing after acceptance have no effect.

Optional Feature:
- Macro: DUAL_AD7528_SHADOW_EN.
- With the macro: shadow_* update to the captured value in the cycle the STROBE phase ends, at the target's register, so the host can read back the current attenuation.
- Without the macro: shadow_* are constant 0 and no shadow flops exist.

Decomposition:
- Shared package dual_ad7528_pkg:
  - typedef dac_target_t enum {LEFT_A=0, LEFT_B=1, RIGHT_A=2, RIGHT_B=3};
  - writer state enum;
  - helpers is_a_side(target) and is_right(target).
- Sub-module dual_ad7528_phase_timer: HALF_PERIOD down-counter with a restart input and a phase_end output.

Test Plan:
- HALF_PERIOD=2, write LEFT_A value 0xA5:
  - datadac sampled at clkdac rises = 1,0,1,0,0,1,0,1;
  - datadac=1 during the csdac1n low pulse of 2 cycles; csdac2n stays 1;
  - wr_done 39 cycles after accept.
- Write RIGHT_B 0x3C -> csdac2n pulses low, datadac=0 during the pulse, csdac1n stays 1.
- Attach a behavioural receiver model; write all four targets with 0x00, 0xFF, 0x80, 0x01 -> the model latches each value into the matching factor register.
- wr_valid held high continuously with 3 queued requests -> accepts spaced exactly 19*HALF_PERIOD+1 cycles apart; no overlapping strobes.
- Assert reset at the BIT_HI of bit 3 -> next cycle all outputs are at reset values, no chip select pulse, and the next write completes normally.
- With DUAL_AD7528_SHADOW_EN, write LEFT_B 0x42 -> shadow_left_b=0x42 at the end of STROBE, other shadows unchanged. Without the macro all shadows read 0.
